uart_rfifo_err: RTL

- Receive-side FIFO of the UART, sitting between the receiver shift logic and the Wishbone register file (RBR read path).
- Buffers received characters, each together with its per-character line-status flags (break, parity error, framing error).
- Reports occupancy and overrun.
- Reports an aggregate error_bit: at least one character still stored in the FIFO carries an error. This drives LSR bit 7.

---
 rtl/uart_rfifo_err_if.sv | 26 ++
 rtl/uart_rfifo_err.sv | 81 ++++++++
 2 files changed

// File: rtl/uart_rfifo_err_if.sv
// Receive-FIFO port bundle: the receiver/register-file side drives the strobes,
// and the FIFO returns the head entry plus its status.
interface uart_rfifo_err_if #(
    parameter int fifo_width     = 11,
    parameter int fifo_counter_w = 5
);
    logic                      push;
    logic                      pop;
    logic [fifo_width-1:0]     data_in;
    logic                      fifo_reset;
    logic                      reset_status;
    logic [fifo_width-1:0]     data_out;
    logic                      overrun;
    logic [fifo_counter_w-1:0] count;
    logic                      error_bit;

    modport master (
        output push, pop, data_in, fifo_reset, reset_status,
        input  data_out, overrun, count, error_bit
    );

    modport slave (
        input  push, pop, data_in, fifo_reset, reset_status,
        output data_out, overrun, count, error_bit
    );
endinterface

// File: rtl/uart_rfifo_err.sv
// UART receive FIFO: characters are kept in RAM and per-entry line-status in flops.
// The status flops are OR-reduced into error_bit, which drives LSR bit 7.
module uart_rfifo_err #(
    parameter int fifo_width     = 11,
    parameter int fifo_depth     = 16,
    parameter int fifo_pointer_w = 4,
    parameter int fifo_counter_w = 5
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    uart_rfifo_err_if.slave   fif
);
    localparam logic [fifo_counter_w-1:0] DEPTH = fifo_counter_w'(fifo_depth);

    logic [fifo_pointer_w-1:0] top, bottom;
    logic [fifo_counter_w-1:0] count_q;
    logic                      overrun_q;
    logic [fifo_width-4:0]     ram    [fifo_depth];
    logic [2:0]                status [fifo_depth];
    logic                      full, empty, do_push, do_pop, ovr_set, err;

    assign full    = (count_q == DEPTH);
    assign empty   = (count_q == '0);
    // A simultaneous pop frees the head slot, so a push while full still fits.
    assign do_push = fif.push & (~full | fif.pop);
    assign do_pop  = fif.pop & ~empty;
    assign ovr_set = fif.push & ~fif.pop & full;

    always_ff @(posedge clk) begin
        if (do_push && !fif.fifo_reset && !wb_rst_i)
            ram[top] <= fif.data_in[fifo_width-1:3];
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            top       <= '0;
            bottom    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else if (fif.fifo_reset) begin
            top       <= '0;
            bottom    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) top    <= top + fifo_pointer_w'(1);
            if (do_pop)  bottom <= bottom + fifo_pointer_w'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + fifo_counter_w'(1);
                2'b01:   count_q <= count_q - fifo_counter_w'(1);
                default: count_q <= count_q;
            endcase
            if (ovr_set)               overrun_q <= 1'b1;
            else if (fif.reset_status) overrun_q <= 1'b0;
        end
    end

    // Write beats clear, so a full push+pop with top==bottom keeps the new flags.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        for (int i = 0; i < fifo_depth; i++) begin
            if (wb_rst_i)
                status[i] <= '0;
            else if (fif.fifo_reset)
                status[i] <= '0;
            else if (do_push && top == fifo_pointer_w'(i))
                status[i] <= fif.data_in[2:0];
            else if (do_pop && bottom == fifo_pointer_w'(i))
                status[i] <= '0;
        end
    end

    always_comb begin
        err = 1'b0;
        for (int i = 0; i < fifo_depth; i++) err = err | (|status[i]);
    end

    assign fif.data_out  = {ram[bottom], status[bottom]};
    assign fif.overrun   = overrun_q;
    assign fif.count     = count_q;
    assign fif.error_bit = err;
endmodule
